// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family and its stream reader.
package fifo_pkg;

    // Default data word width shared by synchronous_fifo and its readers.
    localparam int unsigned DSIZE_DEF = 8;

    // Occupancy of the two-entry head/skid store.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

    // Number of words held for a given occupancy state.
    function automatic logic [1:0] occ_of(input occ_state_e s);
        case (s)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream of the FIFO stream reader.
interface fifo_stream_reader_if #(
    parameter int unsigned DSIZE = fifo_pkg::DSIZE_DEF
);
    logic             fifo_rd_en;
    logic [DSIZE-1:0] fifo_dout;
    logic             fifo_empty;
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;

    // Reader side: drives the FIFO read strobe and the output stream.
    modport master (
        output fifo_rd_en,
        input  fifo_dout,
        input  fifo_empty,
        output m_valid,
        input  m_ready,
        output m_data
    );

    // FIFO/consumer side.
    modport slave (
        input  fifo_rd_en,
        output fifo_dout,
        output fifo_empty,
        input  m_valid,
        output m_ready,
        input  m_data
    );
endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry head/skid store: head drives the output, skid absorbs the word
// that was already in flight when the consumer stalled.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cap_valid,
    input  logic [DSIZE-1:0] cap_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [DSIZE-1:0] out_data,
    output logic [1:0]       occ
);

    occ_state_e       state_q, state_d;
    logic [DSIZE-1:0] head_q, head_d;
    logic [DSIZE-1:0] skid_q, skid_d;
    logic             pop;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;
    assign occ       = occ_of(state_q);
    assign pop       = out_valid && out_ready;

    // Occupancy/next-data decision from capture and pop of this cycle.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (cap_valid) begin
                    head_d  = cap_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                case ({cap_valid, pop})
                    2'b11: head_d = cap_data;
                    2'b10: begin
                        skid_d  = cap_data;
                        state_d = FULL;
                    end
                    2'b01: state_d = EMPTY;
                    default: ;
                endcase
            end
            FULL: begin
                if (pop) begin
                    head_d = skid_q;
                    if (cap_valid) skid_d  = cap_data;
                    else           state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State and data registers; reset discards anything held.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream at one word per cycle,
// counting words accepted downstream.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned CSIZE = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    fifo_stream_reader_if.master bus,
    output logic [CSIZE-1:0]     rd_count,
    output logic                 idle
);

    logic             pending_q, pending_d;
    logic [CSIZE-1:0] count_q, count_d;
    logic             m_valid_w;
    logic [DSIZE-1:0] m_data_w;
    logic [1:0]       occ;
    logic             pop;
    logic             rd_en;
    logic [2:0]       load;

    fifo_skid_buf #(.DSIZE(DSIZE)) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .cap_valid (pending_q),
        .cap_data  (bus.fifo_dout),
        .out_ready (bus.m_ready),
        .out_valid (m_valid_w),
        .out_data  (m_data_w),
        .occ       (occ)
    );

    assign pop = m_valid_w && bus.m_ready;

    // Issue a read only if the word can still be stored once it lands;
    // gated by rstn so no read is requested while reset is held.
    always_comb begin
        load      = 3'(occ) + 3'(pending_q) - 3'(pop);
        rd_en     = rstn && !bus.fifo_empty && (load < 3'd2);
        pending_d = rd_en;
        count_d   = count_q + CSIZE'(pop);
    end

    // In-flight read marker and delivered-word counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q <= 1'b0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = m_valid_w;
    assign bus.m_data     = m_data_w;
    assign rd_count       = count_q;
    assign idle           = (occ == 2'd0) && !pending_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a queue-based FIFO model feeds the
// reader, a negedge monitor checks every delivered word and the handshake.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DSIZE(8)) bus ();
    fifo_stream_reader_if #(.DSIZE(8)) bus4 ();

    logic [15:0] rd_count;
    logic        idle;
    logic [3:0]  rd_count4;
    logic        idle4;

    fifo_stream_reader #(.DSIZE(8), .CSIZE(16)) dut (
        .clk(clk), .rstn(rstn), .bus(bus.master), .rd_count(rd_count), .idle(idle)
    );
    fifo_stream_reader #(.DSIZE(8), .CSIZE(4)) dut4 (
        .clk(clk), .rstn(rstn), .bus(bus4.master), .rd_count(rd_count4), .idle(idle4)
    );

    assign bus4.fifo_dout  = bus.fifo_dout;
    assign bus4.fifo_empty = bus.fifo_empty;
    assign bus4.m_ready    = bus.m_ready;

    int checks = 0;
    int passed = 0;

    logic [7:0] fifoq[$];
    logic [7:0] expq[$];
    int         issued = 0;
    int         delivered = 0;
    bit         last_read = 0;
    bit         rd_en_s = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data = '0;
    int         ready_mode = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor / scoreboard: model occupancy from reads issued minus words delivered.
    always @(negedge clk) begin
        int  held;
        bit  pop_e;
        logic [7:0] w;
        if (!rstn) begin
            check("rst_m_valid", 32'(bus.m_valid), 0);
            check("rst_m_data", 32'(bus.m_data), 0);
            check("rst_idle", 32'(idle), 1);
            check("rst_rd_en", 32'(bus.fifo_rd_en), 0);
            check("rst_rd_count", 32'(rd_count), 0);
            check("rst_rd_count4", 32'(rd_count4), 0);
            issued     = 0;
            delivered  = 0;
            last_read  = 0;
            rd_en_s    = 0;
            prev_stall = 0;
            while (expq.size() > fifoq.size()) void'(expq.pop_front());
        end else begin
            held  = issued - delivered - int'(last_read);
            pop_e = (held > 0) && bus.m_ready;
            check("held_bound", 32'(held <= 2), 1);
            check("m_valid", 32'(bus.m_valid), 32'(held > 0));
            check("m_valid4", 32'(bus4.m_valid), 32'(held > 0));
            check("idle", 32'(idle), 32'(issued == delivered));
            check("idle4", 32'(idle4), 32'(issued == delivered));
            check("rd_en", 32'(bus.fifo_rd_en),
                  32'((fifoq.size() != 0) && (held + int'(last_read) - int'(pop_e) < 2)));
            check("rd_count", 32'(rd_count), 32'(delivered[15:0]));
            check("rd_count4", 32'(rd_count4), 32'(delivered[3:0]));
            if (prev_stall) begin
                check("stall_valid", 32'(bus.m_valid), 1);
                check("stall_data", 32'(bus.m_data), 32'(prev_data));
            end
            if (bus.m_valid && bus.m_ready) begin
                check("word_expected", 32'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    w = expq.pop_front();
                    check("m_data", 32'(bus.m_data), 32'(w));
                    check("m_data4", 32'(bus4.m_data), 32'(w));
                end
                delivered++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            rd_en_s    = bus.fifo_rd_en;
            last_read  = bus.fifo_rd_en;
            issued    += int'(bus.fifo_rd_en);
        end
    end

    // One clock: synchronous FIFO model serves the read seen before the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (rd_en_s && fifoq.size() > 0) bus.fifo_dout = fifoq.pop_front();
        bus.fifo_empty = (fifoq.size() == 0);
        case (ready_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = 1'b0;
            2:       bus.m_ready = ~bus.m_ready;
            default: bus.m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic write(input logic [7:0] w);
        fifoq.push_back(w);
        expq.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((expq.size() != 0 || !idle) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_done", 32'(expq.size() == 0 && idle), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int last;
        int nvalid;
        int base;
        int n;
        bit any;

        bus.m_ready    = 1'b0;
        bus.fifo_dout  = '0;
        bus.fifo_empty = 1'b1;
        rstn = 1'b0;
        repeat (3) cycle();
        rstn = 1'b1;

        // Empty FIFO: reader stays quiet.
        ready_mode = 3;
        any = 0;
        repeat (20) begin
            cycle();
            any |= bus.fifo_rd_en | bus.m_valid | !idle;
        end
        check("empty_quiet", 32'(any), 0);

        // Streaming 0x00..0x0F with m_ready held high.
        ready_mode = 0;
        cycle();
        for (int i = 0; i < 16; i++) write(8'(i));
        first = -1; last = -1; nvalid = 0;
        for (int c = 1; c <= 25; c++) begin
            cycle();
            if (bus.m_valid) begin
                nvalid++;
                if (first < 0) first = c;
                last = c;
            end
        end
        check("stream_first_latency", 32'(first), 2);
        check("stream_last_cycle", 32'(last), 17);
        check("stream_valid_cycles", 32'(nvalid), 16);
        check("stream_rd_count", 32'(rd_count), 16);

        // Backpressure: two words held, reads stop, head stable.
        ready_mode = 1;
        cycle();
        for (int i = 0; i < 4; i++) write(8'(8'hA0 + i));
        repeat (10) cycle();
        check("bp_fifo_left", 32'(fifoq.size()), 2);
        check("bp_rd_en", 32'(bus.fifo_rd_en), 0);
        check("bp_m_valid", 32'(bus.m_valid), 1);
        check("bp_m_data", 32'(bus.m_data), 32'h A0);
        ready_mode = 0;
        drain(30);

        // Toggling m_ready every cycle.
        ready_mode = 2;
        base = delivered;
        for (int i = 0; i < 8; i++) write(8'(8'h30 + i));
        drain(60);
        check("toggle_pops", 32'(delivered - base), 8);

        // Reset mid-stream after 3 of 6 words.
        ready_mode = 0;
        base = delivered;
        for (int i = 0; i < 6; i++) write(8'(8'h60 + i));
        n = 0;
        while (delivered - base < 3 && n < 40) begin
            cycle();
            n++;
        end
        check("midrst_reached", 32'(delivered - base >= 3), 1);
        rstn = 1'b0;
        #1;
        check("midrst_m_valid", 32'(bus.m_valid), 0);
        check("midrst_rd_count", 32'(rd_count), 0);
        check("midrst_rd_en", 32'(bus.fifo_rd_en), 0);
        repeat (2) cycle();
        rstn = 1'b1;
        check("midrst_post_valid", 32'(bus.m_valid), 0);
        drain(40);

        // Counter wrap: CSIZE=4 instance after 17 pops.
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        for (int i = 0; i < 17; i++) write(8'($urandom));
        drain(60);
        check("wrap_rd_count4", 32'(rd_count4), 1);
        check("wrap_rd_count", 32'(rd_count), 17);

        // Randomized writes and consumer readiness.
        ready_mode = 3;
        repeat (400) begin
            cycle();
            if ($urandom_range(0, 2) == 0) write(8'($urandom));
        end
        ready_mode = 0;
        drain(100);
        check("random_fifo_drained", 32'(fifoq.size()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
